// File: rtl/ks_sub_pkg.sv
// Shared constants and stage payload types for the pipelined Kogge-Stone subtractor.
package ks_sub_pkg;

    localparam int WIDTH  = 16;
    localparam int LEVELS = 4;

    typedef struct packed {
        logic [WIDTH-1:0] p;
        logic [WIDTH-1:0] g;
    } pg_vec_t;

    typedef struct packed {
        pg_vec_t pg;
        logic    cin;
        logic    a_msb;
        logic    b_msb;
        logic    sat;
    } s1_t;

    // p0 keeps the bitwise propagate so the sum can be formed after the prefix tree.
    typedef struct packed {
        pg_vec_t          pg;
        logic [WIDTH-1:0] p0;
        logic             cin;
        logic             a_msb;
        logic             b_msb;
        logic             sat;
    } s2_t;

    typedef struct packed {
        logic [WIDTH-1:0] d;
        logic             bout;
        logic             ovf;
        logic             zero;
    } s3_t;

    function automatic logic [WIDTH-1:0] sat_value(input logic a_msb);
        return a_msb ? {1'b1, {(WIDTH-1){1'b0}}} : {1'b0, {(WIDTH-1){1'b1}}};
    endfunction

endpackage

// File: rtl/ks_subtractor_pipe_if.sv
// Operand/result bus of ks_subtractor_pipe; in_sat exists only when KS_SUB_SAT_EN is defined.
interface ks_subtractor_pipe_if;
    import ks_sub_pkg::*;

    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] in_a;
    logic [WIDTH-1:0] in_b;
    logic             in_bin;
`ifdef KS_SUB_SAT_EN
    logic             in_sat;
`endif
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] out_d;
    logic             out_bout;
    logic             out_ovf;
    logic             out_zero;

    modport master (
        output in_valid, in_a, in_b, in_bin,
`ifdef KS_SUB_SAT_EN
        output in_sat,
`endif
        output out_ready,
        input  in_ready, out_valid, out_d, out_bout, out_ovf, out_zero
    );

    modport slave (
        input  in_valid, in_a, in_b, in_bin,
`ifdef KS_SUB_SAT_EN
        input  in_sat,
`endif
        input  out_ready,
        output in_ready, out_valid, out_d, out_bout, out_ovf, out_zero
    );

endinterface

// File: rtl/ks_prefix_level.sv
// One combinational Kogge-Stone prefix level combining each bit with the bit DIST below it.
module ks_prefix_level
    import ks_sub_pkg::*;
#(
    parameter int DIST = 1
) (
    input  pg_vec_t pg_i,
    output pg_vec_t pg_o
);

    for (genvar i = 0; i < WIDTH; i++) begin : g_bit
        if (i < DIST) begin : g_pass
            assign pg_o.g[i] = pg_i.g[i];
            assign pg_o.p[i] = pg_i.p[i];
        end else begin : g_merge
            assign pg_o.g[i] = pg_i.g[i] | (pg_i.p[i] & pg_i.g[i-DIST]);
            assign pg_o.p[i] = pg_i.p[i] & pg_i.p[i-DIST];
        end
    end

endmodule

// File: rtl/ks_subtractor_pipe.sv
// Three-stage Kogge-Stone subtractor D = A - B - bin with borrow, overflow and zero flags.
// Optional saturation on signed overflow is enabled by defining KS_SUB_SAT_EN.
module ks_subtractor_pipe
    import ks_sub_pkg::*;
(
    input  logic                 clk,
    input  logic                 rst,
    ks_subtractor_pipe_if.slave  bus
);

    // Handshake: a transfer happens on a rising edge where valid & ready are both high.
    // Stage k advances when it is empty or the stage after it advances (adv chain ends
    // at out_ready); in_ready is the head of that chain, so there is no skid storage and
    // a stalled stage keeps its payload and valid bit unchanged.
    logic    v1_q, v1_d, v2_q, v2_d, v3_q, v3_d;
    s1_t     s1_q, s1_d;
    s2_t     s2_q, s2_d;
    s3_t     s3_q, s3_d;
    logic    adv1, adv2, adv3;
    logic    in_fire;
    logic    in_sat_w;

    pg_vec_t lvl1, lvl2, lvl3, lvl4;

    logic [WIDTH-1:0] b_not;
    logic [WIDTH-1:0] carry;
    logic [WIDTH-1:0] diff;
    logic [WIDTH-1:0] result;
    logic             cout;
    logic             ovf;

`ifdef KS_SUB_SAT_EN
    assign in_sat_w = bus.in_sat;
`else
    assign in_sat_w = 1'b0;
`endif

    always_comb begin
        adv3 = ~v3_q | bus.out_ready;
        adv2 = ~v2_q | adv3;
        adv1 = ~v1_q | adv2;
    end

    assign bus.in_ready = adv1 & ~rst;
    assign in_fire      = bus.in_valid & bus.in_ready;

    // Stage 1: subtract as A + ~B + ~bin, so the carry-in is the inverted borrow-in.
    always_comb begin
        b_not = ~bus.in_b;
        v1_d  = adv1 ? in_fire : v1_q;
        s1_d  = s1_q;
        if (in_fire) begin
            s1_d.pg.p  = bus.in_a ^ b_not;
            s1_d.pg.g  = bus.in_a & b_not;
            s1_d.cin   = ~bus.in_bin;
            s1_d.a_msb = bus.in_a[WIDTH-1];
            s1_d.b_msb = bus.in_b[WIDTH-1];
            s1_d.sat   = in_sat_w;
        end
    end

    ks_prefix_level #(.DIST(1)) u_lvl1 (.pg_i(s1_q.pg), .pg_o(lvl1));
    ks_prefix_level #(.DIST(2)) u_lvl2 (.pg_i(lvl1),    .pg_o(lvl2));

    always_comb begin
        v2_d = adv2 ? v1_q : v2_q;
        s2_d = s2_q;
        if (adv2 && v1_q) begin
            s2_d.pg    = lvl2;
            s2_d.p0    = s1_q.pg.p;
            s2_d.cin   = s1_q.cin;
            s2_d.a_msb = s1_q.a_msb;
            s2_d.b_msb = s1_q.b_msb;
            s2_d.sat   = s1_q.sat;
        end
    end

    ks_prefix_level #(.DIST(4))             u_lvl3 (.pg_i(s2_q.pg), .pg_o(lvl3));
    ks_prefix_level #(.DIST(1 << (LEVELS-1))) u_lvl4 (.pg_i(lvl3),    .pg_o(lvl4));

    // lvl4 holds group (G,P) over [i:0]; the carry into bit i comes from group i-1.
    always_comb begin
        carry  = {lvl4.g[WIDTH-2:0] | (lvl4.p[WIDTH-2:0] & {(WIDTH-1){s2_q.cin}}), s2_q.cin};
        cout   = lvl4.g[WIDTH-1] | (lvl4.p[WIDTH-1] & s2_q.cin);
        diff   = s2_q.p0 ^ carry;
        ovf    = (s2_q.a_msb != s2_q.b_msb) & (diff[WIDTH-1] != s2_q.a_msb);
        result = (s2_q.sat & ovf) ? sat_value(s2_q.a_msb) : diff;
        v3_d   = adv3 ? v2_q : v3_q;
        s3_d   = s3_q;
        if (adv3 && v2_q) begin
            s3_d.d    = result;
            s3_d.bout = ~cout;
            s3_d.ovf  = ovf;
            s3_d.zero = (result == '0);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            v1_q <= 1'b0;
            v2_q <= 1'b0;
            v3_q <= 1'b0;
            s1_q <= '0;
            s2_q <= '0;
            s3_q <= '0;
        end else begin
            v1_q <= v1_d;
            v2_q <= v2_d;
            v3_q <= v3_d;
            s1_q <= s1_d;
            s2_q <= s2_d;
            s3_q <= s3_d;
        end
    end

    assign bus.out_valid = v3_q;
    assign bus.out_d     = s3_q.d;
    assign bus.out_bout  = s3_q.bout;
    assign bus.out_ovf   = s3_q.ovf;
    assign bus.out_zero  = s3_q.zero;

endmodule

// File: tb/tb_ks_subtractor_pipe.sv
// Directed and random checks of ks_subtractor_pipe against a subtraction reference model.
module tb_ks_subtractor_pipe;
    import ks_sub_pkg::*;

`ifdef KS_SUB_SAT_EN
    localparam bit SAT_EN = 1'b1;
`else
    localparam bit SAT_EN = 1'b0;
`endif

    // clock / reset
    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    ks_subtractor_pipe_if bus ();
    ks_subtractor_pipe dut (.clk(clk), .rst(rst), .bus(bus));

    int n_checks = 0;
    int n_fail   = 0;
    int n_out    = 0;
    int cyc      = 0;
    logic [18:0] exp_q[$];

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h, expected %0h", tag, obs, exp);
        end
    endtask

    // {d, bout, ovf, zero}
    function automatic logic [18:0] model(input logic [15:0] a, input logic [15:0] b,
                                          input logic bin, input logic sat);
        logic [16:0] full;
        logic [15:0] d;
        logic        ovf;
        full = {1'b0, a} - {1'b0, b} - {16'd0, bin};
        d    = full[15:0];
        ovf  = (a[15] != b[15]) && (d[15] != a[15]);
        if (SAT_EN && sat && ovf) d = a[15] ? 16'h8000 : 16'h7FFF;
        return {d, full[16], ovf, (d == 16'h0000)};
    endfunction

    // driver tasks
    task automatic drive_op(input logic [15:0] a, input logic [15:0] b,
                            input logic bin, input logic sat);
        bus.in_valid = 1'b1;
        bus.in_a     = a;
        bus.in_b     = b;
        bus.in_bin   = bin;
`ifdef KS_SUB_SAT_EN
        bus.in_sat   = sat;
`else
        if (sat) bus.in_bin = bin;
`endif
    endtask

    task automatic step(output logic acc, input logic [18:0] exp);
        @(negedge clk);
        acc = bus.in_valid & bus.in_ready;
        if (acc) exp_q.push_back(exp);
        @(posedge clk);
        #1;
    endtask

    task automatic send(input logic [15:0] a, input logic [15:0] b, input logic bin,
                        input logic sat, input logic [18:0] exp);
        logic acc;
        acc = 1'b0;
        drive_op(a, b, bin, sat);
        for (int k = 0; k < 50; k++) begin
            step(acc, exp);
            if (acc) break;
        end
        chk("send_accept", acc, 1);
    endtask

    task automatic send_rand();
        logic [15:0] a;
        logic [15:0] b;
        logic        bin;
        logic        sat;
        a   = 16'($urandom_range(0, 65535));
        b   = 16'($urandom_range(0, 65535));
        bin = 1'($urandom_range(0, 1));
        sat = 1'($urandom_range(0, 1));
        send(a, b, bin, sat, model(a, b, bin, sat));
    endtask

    task automatic drain();
        for (int k = 0; k < 50; k++) begin
            @(negedge clk);
            if (exp_q.size() == 0) break;
        end
        chk("drain_empty", exp_q.size(), 0);
        @(posedge clk);
        #1;
    endtask

    // scoreboard
    always @(negedge clk) begin
        if (!rst && bus.out_valid) begin
            chk("out_pending", exp_q.size() != 0, 1);
            if (exp_q.size() != 0) begin
                if (bus.out_ready) begin
                    chk("result", {bus.out_d, bus.out_bout, bus.out_ovf, bus.out_zero},
                        exp_q.pop_front());
                    n_out++;
                end else begin
                    chk("stall_hold", {bus.out_d, bus.out_bout, bus.out_ovf, bus.out_zero},
                        exp_q[0]);
                end
            end
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic        acc;
        logic [15:0] ra;
        logic [15:0] rb;
        logic        rbin;
        logic        rsat;
        int          lat;
        int          c0;
        int          n0;
        logic [4:0]  stall_ready_exp;

        bus.in_valid  = 1'b0;
        bus.in_a      = '0;
        bus.in_b      = '0;
        bus.in_bin    = 1'b0;
`ifdef KS_SUB_SAT_EN
        bus.in_sat    = 1'b0;
`endif
        bus.out_ready = 1'b0;
        rst           = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_out_valid", bus.out_valid, 0);
        chk("rst_out_d", bus.out_d, 0);
        chk("rst_out_flags", {bus.out_bout, bus.out_ovf, bus.out_zero}, 0);
        chk("rst_in_ready", bus.in_ready, 0);
        rst = 1'b0;
        @(negedge clk);
        chk("in_ready_after_rst", bus.in_ready, 1);
        @(posedge clk);
        #1;

        // latency of a single operation
        bus.out_ready = 1'b1;
        drive_op(16'h0005, 16'h0003, 1'b0, 1'b0);
        step(acc, {16'h0002, 3'b000});
        chk("lat_accept", acc, 1);
        bus.in_valid = 1'b0;
        lat = 0;
        for (int k = 1; k <= 10; k++) begin
            @(negedge clk);
            if (bus.out_valid) begin
                lat = k;
                break;
            end
        end
        chk("latency", lat, 3);
        @(posedge clk);
        #1;

        // directed corner cases, back to back
        send(16'h0000, 16'h0001, 1'b0, 1'b0, {16'hFFFF, 3'b100});
        send(16'h1234, 16'h1234, 1'b1, 1'b0, {16'hFFFF, 3'b100});
        send(16'h8000, 16'h0001, 1'b0, 1'b0, {16'h7FFF, 3'b010});
        send(16'h8000, 16'h0001, 1'b0, 1'b1,
             SAT_EN ? {16'h8000, 3'b010} : {16'h7FFF, 3'b010});
        send(16'h7FFF, 16'h7FFF, 1'b0, 1'b0, {16'h0000, 3'b001});
        send(16'h7FFF, 16'hFFFF, 1'b0, 1'b1,
             SAT_EN ? {16'h7FFF, 3'b110} : {16'h8000, 3'b110});
        bus.in_valid = 1'b0;
        drain();

        // 20 random operations at full throughput
        n0 = n_out;
        c0 = cyc;
        for (int i = 0; i < 20; i++) send_rand();
        chk("throughput_cycles", cyc - c0, 20);
        bus.in_valid = 1'b0;
        drain();
        chk("random_count", n_out - n0, 20);

        // fill with out_ready low, then release
        bus.out_ready   = 1'b0;
        stall_ready_exp = 5'b00111;
        n0   = n_out;
        ra   = 16'($urandom_range(0, 65535));
        rb   = 16'($urandom_range(0, 65535));
        rbin = 1'($urandom_range(0, 1));
        rsat = 1'($urandom_range(0, 1));
        drive_op(ra, rb, rbin, rsat);
        for (int k = 0; k < 5; k++) begin
            step(acc, model(ra, rb, rbin, rsat));
            chk("stall_in_ready", acc, stall_ready_exp[k]);
            if (acc) begin
                ra   = 16'($urandom_range(0, 65535));
                rb   = 16'($urandom_range(0, 65535));
                rbin = 1'($urandom_range(0, 1));
                rsat = 1'($urandom_range(0, 1));
                drive_op(ra, rb, rbin, rsat);
            end
        end
        bus.in_valid  = 1'b0;
        bus.out_ready = 1'b1;
        drain();
        chk("stall_count", n_out - n0, 3);

        // reset with three operations in flight
        bus.out_ready = 1'b0;
        for (int i = 0; i < 3; i++) send_rand();
        bus.in_valid = 1'b0;
        n0  = n_out;
        rst = 1'b1;
        @(negedge clk);
        chk("midrst_in_ready", bus.in_ready, 0);
        @(posedge clk);
        #1;
        chk("midrst_out_valid", bus.out_valid, 0);
        chk("midrst_out_d", bus.out_d, 0);
        exp_q.delete();
        rst           = 1'b0;
        bus.out_ready = 1'b1;
        @(negedge clk);
        chk("postrst_in_ready", bus.in_ready, 1);
        for (int k = 0; k < 5; k++) begin
            chk("postrst_out_valid", bus.out_valid, 0);
            @(negedge clk);
        end
        chk("postrst_no_output", n_out - n0, 0);
        @(posedge clk);
        #1;

        // pipeline still works after reset
        send_rand();
        send(16'h0005, 16'h0003, 1'b0, 1'b0, {16'h0002, 3'b000});
        bus.in_valid = 1'b0;
        drain();

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/ks_subtractor_pipe.md
Name: ks_subtractor_pipe

Overview:
- Pipelined 16-bit Kogge-Stone subtractor: computes D = A - B - bin via A + ~B + ~bin, with a borrow-out flag.
- It is the inverse-direction companion to the team's combinational 16-bit Kogge-Stone adder, built for datapaths that need registered subtract with flow control.
- Three register stages with valid/ready handshake on both sides and full throughput of one operation per cycle.

Parameters:
- WIDTH, 16, operand width; fixed at 16 for this block.
- LEVELS, 4, number of prefix levels, equal to log2(WIDTH).

Ports:
- clk  in  1  single clock; all state updates on rising edge.
- rst  in  1  synchronous, active-high reset.
- in_valid  in  1  input operation valid.
- in_ready  out  1  block can accept an input this cycle.
- in_a  in  16  minuend.
- in_b  in  16  subtrahend.
- in_bin  in  1  borrow-in.
- out_valid  out  1  result valid.
- out_ready  in  1  downstream accepts result.
- out_d  out  16  difference, A - B - bin mod 2^16.
- out_bout  out  1  borrow-out; 1 when the unsigned result is A < B + bin.
- out_ovf  out  1  signed overflow.
- out_zero  out  1  out_d == 0.

Behaviour:
- Reset: synchronous and active-high; clock is clk, reset is rst.
  - While rst is high: all stage valids clear; out_valid=0; out_d=0; out_bout=0; out_ovf=0; out_zero=0; in_ready=0.
  - First cycle after rst deasserts: in_ready=1.
- Arithmetic:
  - Bnot = ~in_b; cin = ~in_bin.
  - P = A ^ Bnot; G = A & Bnot.
  - Prefix distances are 1, 2, 4, 8.
  - Carry into bit i = G[i-1:0] group | (P group & cin).
  - D = P ^ C; cout = group G[15:0] | (group P & cin); bout = ~cout.
  - ovf = (A[15] != B[15]) & (D[15] != A[15]).
- Stages:
  - S1: registers P, G, cin, A[15], B[15].
  - S2: registers prefix results after levels 1-2.
  - S3: registers levels 3-4, D, and flags; drives the out_* ports.
- Latency: 3 cycles from input accept to out_valid with no stall.
- Handshake:
  - Input transfer when in_valid & in_ready; output transfer when out_valid & out_ready.
  - Each stage k has valid bit vk and adv_k = ~vk | adv_{k+1}, where adv_4 = out_ready.
  - in_ready = adv_1, combinational through the chain; no skid buffer.
  - A stalled stage holds its payload and valid.
- Simultaneous events:
  - A stage both emitting and accepting in the same cycle loads the new payload; its valid stays 1.
  - Bubbles collapse as soon as the downstream stage is empty.
- Full pipeline with out_ready=0: in_ready=0, all data held stable, out_* unchanged.
- Reset mid-operation: in-flight operations are discarded without producing output.
- out_* are stable while out_valid=1 and out_ready=0.

Optional Feature:
- Macro: KS_SUB_SAT_EN.
- Defined:
  - Adds input port in_sat (1 bit), carried through the pipeline with its operation.
  - If in_sat=1 and ovf=1: out_d = 0x7FFF when A[15]=0, 0x8000 when A[15]=1.
  - out_ovf still reports the overflow; out_zero is evaluated on the saturated value.
- Undefined: no in_sat port; result always wraps.

Decomposition:
- Shared package ks_sub_pkg:
  - WIDTH and LEVELS constants.
  - Typedefs pg_vec_t (16-bit P/G pair) and stage payload structs s1_t, s2_t, s3_t.
- One sub-module ks_prefix_level, parameter DIST:
  - Combinational single Kogge-Stone level, Gout[i] = G[i] | P[i]&G[i-DIST], Pout[i] = P[i]&P[i-DIST].
  - Bits i < DIST pass through.
  - Instantiated four times, with DIST = 1, 2, 4, 8.

Test Plan:
- A=0x0005, B=0x0003, bin=0, out_ready=1 -> 3 cycles later D=0x0002, bout=0, ovf=0, zero=0.
- A=0x0000, B=0x0001, bin=0 -> D=0xFFFF, bout=1, ovf=0. Also A=0x1234, B=0x1234, bin=1 -> D=0xFFFF, bout=1.
- A=0x8000, B=0x0001 -> D=0x7FFF, ovf=1, bout=0. With KS_SUB_SAT_EN and in_sat=1 -> D=0x8000, ovf=1.
- 20 back-to-back random operations, out_ready=1 -> one result per cycle, in order, all matching the reference model. Then hold out_ready=0 for 5 cycles -> in_ready=0 after the pipeline fills, out_d stable; release -> no loss or duplication.
- 3 operations in flight, assert rst for 1 cycle -> out_valid=0 during and after reset, none of the 3 results ever appears, in_ready=1 the cycle after reset.
- A=0x7FFF, B=0x7FFF, bin=0 -> D=0x0000, zero=1, bout=0, ovf=0.
